// File: rtl/age_rr_arbiter_if.sv
// ============================================================================
// Module      : age_rr_arbiter_if
// Description : Two-source merge handshake bundle for age_rr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface age_rr_arbiter_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 4
);
    logic [DATA_WIDTH-1:0]  a_data;
    logic                   a_vld;
    logic                   a_rdy;
    logic [COUNT_WIDTH-1:0] a_count;
    logic [DATA_WIDTH-1:0]  b_data;
    logic                   b_vld;
    logic                   b_rdy;
    logic [COUNT_WIDTH-1:0] b_count;
    logic                   cnt_en;
    logic [DATA_WIDTH-1:0]  odata;
    logic                   odata_vld;
    logic                   odata_rdy;
    logic [COUNT_WIDTH-1:0] ocount;
    logic                   osrc;

    modport slave (
        input  a_data, a_vld, a_count, b_data, b_vld, b_count, cnt_en, odata_rdy,
        output a_rdy, b_rdy, odata, odata_vld, ocount, osrc
    );

    modport master (
        output a_data, a_vld, a_count, b_data, b_vld, b_count, cnt_en, odata_rdy,
        input  a_rdy, b_rdy, odata, odata_vld, ocount, osrc
    );
endinterface

`default_nettype wire

// File: rtl/age_rr_arbiter.sv
// ============================================================================
// Module      : age_rr_arbiter
// Description : Two-input round-robin arbiter with age override and a single
//               registered output stage that carries the item's age along.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module age_rr_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 4,
    parameter int AGE_LIMIT   = 12,
    parameter int STAT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    age_rr_arbiter_if.slave       bus,
    output logic [STAT_WIDTH-1:0] aged_grants
);

    localparam logic [COUNT_WIDTH-1:0] c_AGE_LIMIT = COUNT_WIDTH'(AGE_LIMIT);

    logic [DATA_WIDTH-1:0]  odata_q, odata_d;
    logic                   odata_vld_q, odata_vld_d;
    logic [COUNT_WIDTH-1:0] ocount_q, ocount_d;
    logic                   osrc_q, osrc_d;
    logic                   last_grant_q, last_grant_d;
    logic [STAT_WIDTH-1:0]  aged_grants_q, aged_grants_d;

    logic w_free;
    logic w_aged_a;
    logic w_aged_b;
    logic w_any_vld;
    logic w_grant_b;
    logic w_age_rule;
    logic w_xfer;

    // Saturating +cnt_en; an already-saturated count must not wrap to zero.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(
        input logic [COUNT_WIDTH-1:0] v,
        input logic                   en
    );
        return (en && (v != '1)) ? v + COUNT_WIDTH'(1) : v;
    endfunction

    always_comb begin
        w_free     = !odata_vld_q || bus.odata_rdy;
        w_aged_a   = bus.a_vld && (bus.a_count >= c_AGE_LIMIT);
        w_aged_b   = bus.b_vld && (bus.b_count >= c_AGE_LIMIT);
        w_any_vld  = bus.a_vld || bus.b_vld;
        w_grant_b  = 1'b0;
        w_age_rule = 1'b0;
        if (bus.a_vld && bus.b_vld) begin
            if ((w_aged_a || w_aged_b) && (bus.a_count != bus.b_count)) begin
                w_grant_b  = bus.b_count > bus.a_count;
                w_age_rule = 1'b1;
            end else begin
                w_grant_b  = !last_grant_q;
            end
        end else if (bus.b_vld) begin
            w_grant_b = 1'b1;
        end
        w_xfer = w_free && w_any_vld;
    end

    assign bus.a_rdy = w_free && bus.a_vld && !w_grant_b;
    assign bus.b_rdy = w_free && bus.b_vld && w_grant_b;

    always_comb begin
        odata_d       = odata_q;
        odata_vld_d   = odata_vld_q;
        ocount_d      = ocount_q;
        osrc_d        = osrc_q;
        last_grant_d  = last_grant_q;
        aged_grants_d = aged_grants_q;
        if (w_xfer) begin
            odata_d      = w_grant_b ? bus.b_data : bus.a_data;
            osrc_d       = w_grant_b;
            odata_vld_d  = 1'b1;
            last_grant_d = w_grant_b;
            ocount_d     = sat_inc(w_grant_b ? bus.b_count : bus.a_count, bus.cnt_en);
            if (w_age_rule && (aged_grants_q != '1)) begin
                aged_grants_d = aged_grants_q + STAT_WIDTH'(1);
            end
        end else if (odata_vld_q && bus.odata_rdy) begin
            odata_vld_d = 1'b0;
        end else if (odata_vld_q) begin
            // Held item keeps ageing while downstream stalls.
            ocount_d = sat_inc(ocount_q, bus.cnt_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odata_q       <= '0;
            odata_vld_q   <= 1'b0;
            ocount_q      <= '0;
            osrc_q        <= 1'b0;
            last_grant_q  <= 1'b1;
            aged_grants_q <= '0;
        end else begin
            odata_q       <= odata_d;
            odata_vld_q   <= odata_vld_d;
            ocount_q      <= ocount_d;
            osrc_q        <= osrc_d;
            last_grant_q  <= last_grant_d;
            aged_grants_q <= aged_grants_d;
        end
    end

    assign bus.odata     = odata_q;
    assign bus.odata_vld = odata_vld_q;
    assign bus.ocount    = ocount_q;
    assign bus.osrc      = osrc_q;
    assign aged_grants   = aged_grants_q;

endmodule

`default_nettype wire
